// File: rtl/rca110_core_mem_if.sv
// rca110_core_mem_if: RCA110 CPU memory port plus bootstrap loader port.
// master = CPU/loader side, slave = core-store responder.
interface rca110_core_mem_if #(
   parameter int unsigned ADR_W = 12,
   parameter int unsigned DAT_W = 24
);
   logic             mm_req;
   logic [ADR_W-1:0] mm_adr;
   logic             mm_we;
   logic [DAT_W-1:0] mm_odat;
   logic [DAT_W-1:0] mm_idat;
   logic             mm_rdy;
   logic             mm_busy;
   logic             ld_we;
   logic [ADR_W-1:0] ld_adr;
   logic [DAT_W-1:0] ld_dat;

   modport master (
      output mm_req, mm_adr, mm_we, mm_odat, ld_we, ld_adr, ld_dat,
      input  mm_idat, mm_rdy, mm_busy
   );

   modport slave (
      input  mm_req, mm_adr, mm_we, mm_odat, ld_we, ld_adr, ld_dat,
      output mm_idat, mm_rdy, mm_busy
   );
endinterface

// File: rtl/rca110_core_mem.sv
// rca110_core_mem: magnetic-core store responder (destructive read + restore) for the RCA110.
// Build option RCA110_MEM_PARITY_EN adds an odd-parity bit per stored word and drives o_perr.
module rca110_core_mem #(
   parameter int unsigned ADR_W    = 12,
   parameter int unsigned DAT_W    = 24,
   parameter int unsigned DEPTH    = 4096,
   parameter int unsigned CYC_WAIT = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   rca110_core_mem_if.slave mm,
   output logic             o_ovr,
   output logic             o_perr
);
`ifdef RCA110_MEM_PARITY_EN
   localparam int unsigned SW = DAT_W + 1;
`else
   localparam int unsigned SW = DAT_W;
`endif
   localparam int unsigned IW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CLR  = 3'd2,
      ST_RS   = 3'd3,
      ST_WR   = 3'd4
   } state_t;

   function automatic logic [SW-1:0] enc_f(input logic [DAT_W-1:0] d);
`ifdef RCA110_MEM_PARITY_EN
      return {~^d, d};
`else
      return d;
`endif
   endfunction

   function automatic logic [IW-1:0] idx_f(input logic [ADR_W-1:0] a);
      return IW'(32'(a) % DEPTH);
   endfunction

   logic [SW-1:0]    store_r [0:DEPTH-1];
   state_t           state_r;
   logic [3:0]       wcnt_r;
   logic [ADR_W-1:0] adr_r;
   logic [DAT_W-1:0] odat_r;
   logic [SW-1:0]    sense_r;
   logic [DAT_W-1:0] idat_r;
   logic             rdy_r;
   logic             busy_r;
   logic             ovr_r;
   logic             perr_r;

   logic             first_s;
   logic             last_s;
   logic             perr_s;
   logic [SW-1:0]    sense_s;
   logic             st_we_s;
   logic [IW-1:0]    st_idx_s;
   logic [SW-1:0]    st_dat_s;

   // Phase position and the word currently seen by the sense amplifiers.
   always_comb begin
      first_s = (wcnt_r == 4'd0);
      last_s  = (wcnt_r == 4'(CYC_WAIT));
      if (first_s) begin
         sense_s = store_r[idx_f(adr_r)];
      end else begin
         sense_s = sense_r;
      end
   end

`ifdef RCA110_MEM_PARITY_EN
   assign perr_s = ~(^sense_s);
`else
   assign perr_s = 1'b0;
`endif

   // Single store write port; reset blocks the write so an aborted read stays cleared.
   always_comb begin
      st_we_s  = 1'b0;
      st_idx_s = idx_f(adr_r);
      st_dat_s = enc_f({DAT_W{1'b0}});
      if (!i_rst) begin
         case (state_r)
            ST_IDLE: begin
               if (mm.ld_we) begin
                  st_we_s  = 1'b1;
                  st_idx_s = idx_f(mm.ld_adr);
                  st_dat_s = enc_f(mm.ld_dat);
               end else begin
                  st_we_s  = 1'b0;
               end
            end
            ST_RD, ST_CLR: begin
               st_we_s = first_s;
            end
            ST_RS: begin
               st_we_s  = 1'b1;
               st_dat_s = enc_f(sense_r[DAT_W-1:0]);
            end
            ST_WR: begin
               st_we_s  = 1'b1;
               st_dat_s = enc_f(odat_r);
            end
            default: begin
               st_we_s = 1'b0;
            end
         endcase
      end else begin
         st_we_s = 1'b0;
      end
   end

   // Core array; contents deliberately survive reset.
   always_ff @(posedge i_clk) begin
      if (st_we_s) begin
         store_r[st_idx_s] <= st_dat_s;
      end
   end

   // Access sequencer: accept, phase 1 (RD/CLR), phase 2 (RS/WR), overrun tracking.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
         wcnt_r  <= 4'd0;
         adr_r   <= {ADR_W{1'b0}};
         odat_r  <= {DAT_W{1'b0}};
         sense_r <= {SW{1'b0}};
         idat_r  <= {DAT_W{1'b0}};
         rdy_r   <= 1'b0;
         busy_r  <= 1'b0;
         ovr_r   <= 1'b0;
         perr_r  <= 1'b0;
      end else begin
         rdy_r  <= 1'b0;
         perr_r <= 1'b0;
         if ((state_r != ST_IDLE) && (mm.mm_req || mm.ld_we)) begin
            ovr_r <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               wcnt_r <= 4'd0;
               if (mm.ld_we) begin
                  if (mm.mm_req) begin
                     ovr_r <= 1'b1;
                  end
               end else if (mm.mm_req) begin
                  adr_r   <= mm.mm_adr;
                  odat_r  <= mm.mm_odat;
                  busy_r  <= 1'b1;
                  state_r <= mm.mm_we ? ST_CLR : ST_RD;
               end
            end
            ST_RD: begin
               sense_r <= sense_s;
               if (last_s) begin
                  idat_r  <= sense_s[DAT_W-1:0];
                  rdy_r   <= 1'b1;
                  perr_r  <= perr_s;
                  wcnt_r  <= 4'd0;
                  state_r <= ST_RS;
               end else begin
                  wcnt_r <= wcnt_r + 4'd1;
               end
            end
            ST_CLR: begin
               if (last_s) begin
                  rdy_r   <= 1'b1;
                  wcnt_r  <= 4'd0;
                  state_r <= ST_WR;
               end else begin
                  wcnt_r <= wcnt_r + 4'd1;
               end
            end
            ST_RS, ST_WR: begin
               if (last_s) begin
                  busy_r  <= 1'b0;
                  wcnt_r  <= 4'd0;
                  state_r <= ST_IDLE;
               end else begin
                  wcnt_r <= wcnt_r + 4'd1;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               wcnt_r  <= 4'd0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign mm.mm_idat = idat_r;
   assign mm.mm_rdy  = rdy_r;
   assign mm.mm_busy = busy_r;
   assign o_ovr      = ovr_r;
   assign o_perr     = perr_r;
endmodule

// File: tb/tb_rca110_core_mem.sv
// tb_rca110_core_mem: random + directed checks of rca110_core_mem against a word-array model.
// dut0: CYC_WAIT=0, DEPTH=4096; dut3: CYC_WAIT=3, DEPTH=1024 (address wrap, wait states).
module tb_rca110_core_mem;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rca110_core_mem_if #(.ADR_W(12), .DAT_W(24)) bus0 ();
   rca110_core_mem_if #(.ADR_W(12), .DAT_W(24)) bus3 ();
   logic ovr0, perr0, ovr3, perr3;

   rca110_core_mem #(.ADR_W(12), .DAT_W(24), .DEPTH(4096), .CYC_WAIT(0)) dut0 (
      .i_clk(clk), .i_rst(rst), .mm(bus0), .o_ovr(ovr0), .o_perr(perr0));
   rca110_core_mem #(.ADR_W(12), .DAT_W(24), .DEPTH(1024), .CYC_WAIT(3)) dut3 (
      .i_clk(clk), .i_rst(rst), .mm(bus3), .o_ovr(ovr3), .o_perr(perr3));

   int          total_cnt = 0;
   int          bad_cnt   = 0;
   logic [23:0] mem_m [0:4095];
   logic [23:0] idat_m0;
   logic [11:0] pool [0:15];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic get_rdy(input bit s);
      return s ? bus3.mm_rdy : bus0.mm_rdy;
   endfunction
   function automatic logic get_busy(input bit s);
      return s ? bus3.mm_busy : bus0.mm_busy;
   endfunction
   function automatic logic [23:0] get_idat(input bit s);
      return s ? bus3.mm_idat : bus0.mm_idat;
   endfunction
   function automatic logic get_perr(input bit s);
      return s ? perr3 : perr0;
   endfunction

   task automatic drive_req(input bit s, input logic r, input logic we, input logic [11:0] a,
                            input logic [23:0] d);
      if (s) begin
         bus3.mm_req = r; bus3.mm_we = we; bus3.mm_adr = a; bus3.mm_odat = d;
      end else begin
         bus0.mm_req = r; bus0.mm_we = we; bus0.mm_adr = a; bus0.mm_odat = d;
      end
   endtask

   task automatic drive_ld(input bit s, input logic w, input logic [11:0] a, input logic [23:0] d);
      if (s) begin
         bus3.ld_we = w; bus3.ld_adr = a; bus3.ld_dat = d;
      end else begin
         bus0.ld_we = w; bus0.ld_adr = a; bus0.ld_dat = d;
      end
   endtask

   task automatic wait_idle(input bit s);
      int idle_at = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (!get_busy(s)) begin
            idle_at = n;
            break;
         end
      end
      check_val("idle_timeout", 32'(idle_at < 0), 32'd0);
   endtask

   // One full access; latencies count edges after the accepting edge.
   task automatic access(input bit s, input logic we, input logic [11:0] a, input logic [23:0] wd,
                         output logic [23:0] rd, output logic pe, output int rdy_at,
                         output int idle_at, output int rdy_n);
      @(negedge clk); drive_req(s, 1'b1, we, a, wd);
      @(posedge clk); #1; drive_req(s, 1'b0, 1'b0, 12'h000, 24'h000000);
      check_val("busy_on_accept", 32'(get_busy(s)), 32'd1);
      rd = get_idat(s); pe = 1'b0; rdy_at = -1; idle_at = -1; rdy_n = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (get_rdy(s)) begin
            rdy_n++; rdy_at = n; rd = get_idat(s); pe = get_perr(s);
         end
         if (!get_busy(s)) begin
            idle_at = n;
            break;
         end
      end
      check_val("access_timeout", 32'(idle_at < 0), 32'd0);
   endtask

   task automatic do_load(input bit s, input logic [11:0] a, input logic [23:0] d);
      @(negedge clk); drive_ld(s, 1'b1, a, d);
      @(posedge clk); #1; drive_ld(s, 1'b0, 12'h000, 24'h000000);
      check_val("ld_busy", 32'(get_busy(s)), 32'd0);
      if (!s) mem_m[a] = d;
   endtask

   task automatic do_read(input logic [11:0] a, input logic pe_exp, input string tag);
      logic [23:0] rd; logic pe; int ra, ia, rn;
      access(1'b0, 1'b0, a, 24'h000000, rd, pe, ra, ia, rn);
      check_val({tag, "_data"}, 32'(rd), 32'(mem_m[a]));
      check_val({tag, "_rdy_at"}, ra, 32'd1);
      check_val({tag, "_rdy_n"}, rn, 32'd1);
      check_val({tag, "_busy_len"}, ia, 32'd2);
      check_val({tag, "_perr"}, 32'(pe), 32'(pe_exp));
      idat_m0 = mem_m[a];
   endtask

   task automatic do_write(input logic [11:0] a, input logic [23:0] d, input string tag);
      logic [23:0] rd; logic pe; int ra, ia, rn;
      access(1'b0, 1'b1, a, d, rd, pe, ra, ia, rn);
      check_val({tag, "_idat_hold"}, 32'(rd), 32'(idat_m0));
      check_val({tag, "_rdy_at"}, ra, 32'd1);
      check_val({tag, "_rdy_n"}, rn, 32'd1);
      check_val({tag, "_busy_len"}, ia, 32'd2);
      mem_m[a] = d;
   endtask

   initial begin
      logic [23:0] rd; logic pe; int ra, ia, rn;
      logic [11:0] a; logic [23:0] d;
      rst = 1'b1;
      drive_req(1'b0, 1'b0, 1'b0, 12'h000, 24'h000000); drive_ld(1'b0, 1'b0, 12'h000, 24'h000000);
      drive_req(1'b1, 1'b0, 1'b0, 12'h000, 24'h000000); drive_ld(1'b1, 1'b0, 12'h000, 24'h000000);
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      check_val("rst_idat", 32'(bus0.mm_idat), 32'd0);
      check_val("rst_rdy", 32'(bus0.mm_rdy), 32'd0);
      check_val("rst_busy", 32'(bus0.mm_busy), 32'd0);
      check_val("rst_ovr", 32'(ovr0), 32'd0);
      check_val("rst_perr", 32'(perr0), 32'd0);
      idat_m0 = 24'h000000;

      for (int k = 0; k < 16; k++) begin
         pool[k] = (k == 15) ? 12'hFFF : 12'(k * 257);
         do_load(1'b0, pool[k], 24'($urandom));
      end

      // Loader load and its read-back twice (restore after destructive read).
      do_load(1'b0, 12'o100, 24'h0D2002);
      do_read(12'o100, 1'b0, "t1_rd1");
      do_read(12'o100, 1'b0, "t1_rd2");
      do_write(12'o7, 24'hABCDEF, "t2_wr");
      do_read(12'o7, 1'b0, "t2_rd");

      // Loader and request together in IDLE: loader wins, request dropped.
      do_load(1'b0, 12'o102, 24'h010203);
      @(negedge clk);
      drive_req(1'b0, 1'b1, 1'b1, 12'o102, 24'hDEAD01);
      drive_ld(1'b0, 1'b1, 12'o103, 24'h0C0C03);
      @(posedge clk); #1;
      drive_req(1'b0, 1'b0, 1'b0, 12'h000, 24'h000000); drive_ld(1'b0, 1'b0, 12'h000, 24'h000000);
      check_val("coll_ovr", 32'(ovr0), 32'd1);
      check_val("coll_busy", 32'(bus0.mm_busy), 32'd0);
      mem_m[12'o103] = 24'h0C0C03;
      do_read(12'o102, 1'b0, "coll_rd_req");
      do_read(12'o103, 1'b0, "coll_rd_ld");

      // Reset during the restore half-cycle leaves the word cleared.
      do_load(1'b0, 12'o200, 24'h123456);
      @(negedge clk); drive_req(1'b0, 1'b1, 1'b0, 12'o200, 24'h000000);
      @(posedge clk); #1; drive_req(1'b0, 1'b0, 1'b0, 12'h000, 24'h000000);
      @(posedge clk); #1;
      check_val("t4_rdy", 32'(bus0.mm_rdy), 32'd1);
      check_val("t4_data", 32'(bus0.mm_idat), 32'h123456);
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      check_val("t4_rst_busy", 32'(bus0.mm_busy), 32'd0);
      check_val("t4_rst_idat", 32'(bus0.mm_idat), 32'd0);
      check_val("t4_rst_ovr", 32'(ovr0), 32'd0);
      mem_m[12'o200] = 24'h000000; idat_m0 = 24'h000000;
      do_read(12'o200, 1'b0, "t4_rd");

      // Requests and loader strobes during busy are dropped and set the sticky overrun.
      @(negedge clk); drive_req(1'b0, 1'b1, 1'b0, 12'o100, 24'h000000);
      @(posedge clk); #1;
      drive_req(1'b0, 1'b1, 1'b1, pool[1], 24'h555555);
      drive_ld(1'b0, 1'b1, 12'o7, 24'h777777);
      @(posedge clk); #1;
      drive_req(1'b0, 1'b0, 1'b0, 12'h000, 24'h000000); drive_ld(1'b0, 1'b0, 12'h000, 24'h000000);
      check_val("t3_rd_data", 32'(bus0.mm_idat), 32'(mem_m[12'o100]));
      wait_idle(1'b0);
      check_val("t3_ovr", 32'(ovr0), 32'd1);
      idat_m0 = mem_m[12'o100];
      do_read(pool[1], 1'b0, "t3_keep_req");
      do_read(12'o7, 1'b0, "t3_keep_ld");

      for (int i = 0; i < 60; i++) begin
         a = pool[$urandom_range(0, 15)];
         d = 24'($urandom);
         case ($urandom_range(0, 2))
            0:       do_load(1'b0, a, d);
            1:       do_write(a, d, "rnd_wr");
            default: do_read(a, 1'b0, "rnd_rd");
         endcase
      end
      check_val("ovr_sticky", 32'(ovr0), 32'd1);

`ifdef RCA110_MEM_PARITY_EN
      do_load(1'b0, 12'o300, 24'h00F00F);
      do_load(1'b0, 12'o301, 24'h00F00E);
      @(negedge clk);
      dut0.store_r[12'o300][24] = ~dut0.store_r[12'o300][24];
      do_read(12'o300, 1'b1, "par_bad");
      do_read(12'o301, 1'b0, "par_ok");
`endif

      // Wait states and address wrap on the CYC_WAIT=3 / DEPTH=1024 instance.
      do_load(1'b1, 12'h005, 24'h0A0A05);
      access(1'b1, 1'b0, 12'hC05, 24'h000000, rd, pe, ra, ia, rn);
      check_val("w3_rd_data", 32'(rd), 32'h0A0A05);
      check_val("w3_rd_rdy_at", ra, 32'd4);
      check_val("w3_rd_rdy_n", rn, 32'd1);
      check_val("w3_rd_busy_len", ia, 32'd8);
      access(1'b1, 1'b1, 12'h7FF, 24'h3C3C3C, rd, pe, ra, ia, rn);
      check_val("w3_wr_idat_hold", 32'(rd), 32'h0A0A05);
      check_val("w3_wr_rdy_at", ra, 32'd4);
      check_val("w3_wr_busy_len", ia, 32'd8);
      access(1'b1, 1'b0, 12'h3FF, 24'h000000, rd, pe, ra, ia, rn);
      check_val("w3_wrap_data", 32'(rd), 32'h3C3C3C);
      access(1'b1, 1'b0, 12'h005, 24'h000000, rd, pe, ra, ia, rn);
      check_val("w3_restore_data", 32'(rd), 32'h0A0A05);
      check_val("w3_ovr", 32'(ovr3), 32'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end
endmodule
